vga_draw_arbiter: RTL

- Shares the single VGA adapter write port (x, y, colour, plot) between sprite-drawing FSMs: player, alien bank and bullets.
- Each requester draws a burst of pixels. The arbiter grants one requester at a time, round-robin, and holds the grant until that requester's last pixel.
- All outputs to the VGA adapter are registered.
- Sits between the sprite FSMs/datapaths and the VGA adapter.

---
 rtl/vga_draw_arbiter.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/vga_draw_arbiter.sv
// vga_draw_arbiter
//   Shares the single VGA adapter write port between the sprite-drawing FSMs
//   (index 0 = player, then alien bank, bullets). One requester is granted at a
//   time, round-robin, and keeps the grant until its last pixel, a dropped
//   request, or a hold timeout. All VGA-side outputs are registered.
//
//   Optional feature, macro VGA_FRAME_CLEAR_EN: a frame_tick queues a
//   full-screen clear sweep (colour 0) that runs from IDLE before the next grant.
//
// Ports
//   clk, reset_n            clock, synchronous active-low reset
//   frame_tick              one-cycle pulse per frame
//   req / wr / last         per-requester request level, pixel strobe, final pixel
//   req_x/req_y/req_colour  flattened per-requester pixel data (slice i)
//   gnt                     one-hot grant (registered)
//   vga_x/vga_y/vga_colour  registered pixel to the VGA adapter
//   vga_plot                registered write enable to the VGA adapter
//   busy                    state != IDLE
//   hold_err                sticky, set when a grant is released by timeout
module vga_draw_arbiter #(
    parameter int N_REQ    = 3,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COL_W    = 3,
    parameter int MAX_HOLD = 64,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   frame_tick,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       wr,
    input  logic [N_REQ-1:0]       last,
    input  logic [N_REQ*X_W-1:0]   req_x,
    input  logic [N_REQ*Y_W-1:0]   req_y,
    input  logic [N_REQ*COL_W-1:0] req_colour,
    output logic [N_REQ-1:0]       gnt,
    output logic [X_W-1:0]         vga_x,
    output logic [Y_W-1:0]         vga_y,
    output logic [COL_W-1:0]       vga_colour,
    output logic                   vga_plot,
    output logic                   busy,
    output logic                   hold_err
);

    localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

`ifdef VGA_FRAME_CLEAR_EN
    typedef enum logic [1:0] {IDLE, GRANT, CLEAR} state_t;
`else
    typedef enum logic {IDLE, GRANT} state_t;
`endif

    state_t             state;
    logic [IDX_W-1:0]   g_idx;
    logic [IDX_W-1:0]   rr_ptr;
    logic [HOLD_W-1:0]  hold_cnt;

    logic               sel_valid;
    logic [IDX_W-1:0]   sel_idx;
    logic [N_REQ-1:0]   sel_oh;
    logic [X_W-1:0]     g_x;
    logic [Y_W-1:0]     g_y;
    logic [COL_W-1:0]   g_colour;
    logic               g_wr, g_last, g_req;
    logic               timeout;
    logic [IDX_W-1:0]   next_ptr;

`ifdef VGA_FRAME_CLEAR_EN
    logic               clear_pend;
    logic [X_W-1:0]     clr_x;
    logic [Y_W-1:0]     clr_y;
`else
    logic               unused_cfg;
    assign unused_cfg = frame_tick ^ (SCREEN_W > 0) ^ (SCREEN_H > 0);
`endif

    // Round-robin pick: first set req at offset k from rr_ptr, modulo N_REQ.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        sel_oh    = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            for (int unsigned j = 0; j < N_REQ; j++) begin
                if (!sel_valid && req[j] && ((32'(rr_ptr) + k) % N_REQ) == j) begin
                    sel_valid = 1'b1;
                    sel_idx   = IDX_W'(j);
                    sel_oh    = '0;
                    sel_oh[j] = 1'b1;
                end
            end
        end
    end

    // Granted requester's slice.
    always_comb begin
        g_x      = '0;
        g_y      = '0;
        g_colour = '0;
        g_wr     = 1'b0;
        g_last   = 1'b0;
        g_req    = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (g_idx == IDX_W'(i)) begin
                g_x      = req_x[i*X_W +: X_W];
                g_y      = req_y[i*Y_W +: Y_W];
                g_colour = req_colour[i*COL_W +: COL_W];
                g_wr     = wr[i];
                g_last   = last[i];
                g_req    = req[i];
            end
        end
    end

    assign timeout  = (hold_cnt == HOLD_W'(MAX_HOLD - 1));
    assign next_ptr = (g_idx == IDX_W'(N_REQ - 1)) ? '0 : g_idx + 1'b1;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            gnt        <= '0;
            g_idx      <= '0;
            rr_ptr     <= '0;
            hold_cnt   <= '0;
            hold_err   <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
`ifdef VGA_FRAME_CLEAR_EN
            clear_pend <= 1'b0;
            clr_x      <= '0;
            clr_y      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    gnt      <= '0;
                    vga_plot <= 1'b0;
                    hold_cnt <= '0;
`ifdef VGA_FRAME_CLEAR_EN
                    if (clear_pend) begin
                        state      <= CLEAR;
                        clear_pend <= 1'b0;
                        clr_x      <= '0;
                        clr_y      <= '0;
                    end else
`endif
                    if (sel_valid) begin
                        state <= GRANT;
                        gnt   <= sel_oh;
                        g_idx <= sel_idx;
                    end
                end
                GRANT: begin
                    vga_x      <= g_x;
                    vga_y      <= g_y;
                    vga_colour <= g_colour;
                    vga_plot   <= g_wr;
                    if (!timeout)
                        hold_cnt <= hold_cnt + 1'b1;
                    if ((g_wr && g_last) || !g_req || timeout) begin
                        state  <= IDLE;
                        gnt    <= '0;
                        rr_ptr <= next_ptr;
                        // Only a genuine timeout flags an error, not a normal
                        // release that happens to land on the final count.
                        if (timeout && g_req && !(g_wr && g_last))
                            hold_err <= 1'b1;
                    end
                end
`ifdef VGA_FRAME_CLEAR_EN
                CLEAR: begin
                    gnt        <= '0;
                    vga_x      <= clr_x;
                    vga_y      <= clr_y;
                    vga_colour <= '0;
                    vga_plot   <= 1'b1;
                    if (clr_x == X_W'(SCREEN_W - 1)) begin
                        clr_x <= '0;
                        if (clr_y == Y_W'(SCREEN_H - 1)) begin
                            clr_y <= '0;
                            state <= IDLE;
                        end else begin
                            clr_y <= clr_y + 1'b1;
                        end
                    end else begin
                        clr_x <= clr_x + 1'b1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
`ifdef VGA_FRAME_CLEAR_EN
            // Placed after the case so a tick on the CLEAR-entry cycle is kept.
            if (frame_tick)
                clear_pend <= 1'b1;
`endif
        end
    end

endmodule
